// File: rtl/_mul16_seq.sv
// Iterative shift-add unsigned multiplier: N x N -> 2N, one multiplier bit per clock.
// A start/busy/done handshake accepts a new operation in IDLE or directly from DONE.
module _mul16_seq #(
    parameter int N = 16
) (
    input  logic           in_clk,
    input  logic           in_reset,
    input  logic           in_start,
    input  logic [0:N-1]   in_a,
    input  logic [0:N-1]   in_b,
    output logic           out_busy,
    output logic           out_done,
    output logic [0:2*N-1] out_p
);
    // state | meaning
    // IDLE  | waiting for in_start; out_p holds last product
    // RUN   | N shift-add steps, one multiplier bit per edge
    // DONE  | out_done pulse; in_start here chains straight into RUN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_in, b_in, a_reg, b_reg, a_sel, b_sel, pp;
    logic [2*N-1:0] acc, acc_next;
    logic [N:0]    sum;
    logic [CW-1:0] count;

    assign a_in = in_a;
    assign b_in = in_b;

    // per-bit partial-product gating and operand load selection
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign pp[i]    = a_reg[i] & b_reg[0];
        assign a_sel[i] = in_start ? a_in[i] : a_reg[i];
        assign b_sel[i] = in_start ? b_in[i] : b_reg[i];
    end

    // carry out of the upper-half add becomes the new acc MSB after the shift
    assign sum      = {1'b0, acc[2*N-1:N]} + {1'b0, pp};
    assign acc_next = {sum, acc[N-1:1]};

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            count    <= '0;
            out_busy <= 1'b0;
            out_done <= 1'b0;
            out_p    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    out_done <= 1'b0;
                    a_reg    <= a_sel;
                    b_reg    <= b_sel;
                    if (in_start) begin
                        acc      <= '0;
                        count    <= '0;
                        out_busy <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state    <= S_DONE;
                        out_busy <= 1'b0;
                        out_done <= 1'b1;
                        out_p    <= acc_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb__mul16_seq.sv
// Bench for _mul16_seq: cycle-level reference model checked every cycle, plus directed
// vectors with literal products/latencies and a random sweep against a*b.
module tb__mul16_seq;
    logic        in_clk, in_reset, in_start;
    logic [0:15] in_a, in_b;
    logic        out_busy, out_done;
    logic [0:31] out_p;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    _mul16_seq #(.N(16)) dut (
        .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
        .in_a(in_a), .in_b(in_b),
        .out_busy(out_busy), .out_done(out_done), .out_p(out_p)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted operation keeps the unit busy for 16 cycles, then the
    // product appears with a one-cycle done; start is honoured whenever not busy.
    int          m_rem;
    logic        m_done;
    logic [31:0] m_pend, m_p;
    always @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            m_rem = 0; m_done = 1'b0; m_p = '0; m_pend = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_p = m_pend;
            end
        end else begin
            m_done = 1'b0;
            if (in_start) begin
                m_pend = 32'(in_a) * 32'(in_b);
                m_rem = 16;
            end
        end
    end

    always @(negedge in_clk) begin
        chk("busy", {31'd0, out_busy}, {31'd0, m_rem > 0});
        chk("done", {31'd0, out_done}, {31'd0, m_done});
        chk("p",    out_p, m_p);
        if (out_done) done_cnt++;
    end

    // Called just after a negedge; returns at the negedge where out_done is seen.
    task automatic wait_done(inout int cyc);
        while (!out_done && cyc < 60) begin
            @(negedge in_clk);
            cyc++;
        end
        if (!out_done) chk("done_timeout", 32'(cyc), 32'd17);
    endtask

    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
        int cyc;
        in_a = a; in_b = b; in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0; cyc = 1;
        in_a = 16'($urandom); in_b = 16'($urandom);
        wait_done(cyc);
        chk({name, "_lat"}, 32'(cyc), 32'd17);
        chk({name, "_p"}, out_p, exp);
        @(negedge in_clk);
    endtask

    initial begin
        int cyc, d0, t1;
        logic [15:0] ra, rb;
        in_reset = 1'b1; in_start = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge in_clk);
        chk("rst_busy", {31'd0, out_busy}, 32'd0);
        chk("rst_done", {31'd0, out_done}, 32'd0);
        chk("rst_p", out_p, 32'd0);
        in_reset = 1'b0;
        @(negedge in_clk);

        do_op("t1", 16'd3, 16'd5, 32'h0000000F);
        do_op("t2", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        do_op("t3a", 16'h1234, 16'h0000, 32'h00000000);
        do_op("t3b", 16'h0000, 16'hABCD, 32'h00000000);
        do_op("t_msb", 16'h8000, 16'h8000, 32'h40000000);

        // start pulsed mid-run is ignored
        d0 = done_cnt;
        in_a = 16'd7; in_b = 16'd9; in_start = 1'b1;
        @(negedge in_clk); in_start = 1'b0; cyc = 1;
        repeat (4) begin @(negedge in_clk); cyc++; end
        in_a = 16'd2; in_b = 16'd2; in_start = 1'b1;
        @(negedge in_clk); in_start = 1'b0; cyc++;
        wait_done(cyc);
        chk("t4_lat", 32'(cyc), 32'd17);
        chk("t4_p", out_p, 32'h0000003F);
        repeat (20) @(negedge in_clk);
        chk("t4_ndone", 32'(done_cnt - d0), 32'd1);

        // start held across DONE: back-to-back accept
        in_a = 16'h0011; in_b = 16'h0011; in_start = 1'b1;
        @(negedge in_clk); in_start = 1'b0; cyc = 1;
        repeat (15) begin @(negedge in_clk); cyc++; end
        in_a = 16'h0100; in_b = 16'h0100; in_start = 1'b1;
        @(negedge in_clk); cyc++;
        wait_done(cyc);
        chk("t5_p1", out_p, 32'h00000121);
        t1 = cyc;
        @(negedge in_clk); in_start = 1'b0; cyc++;
        wait_done(cyc);
        chk("t5_gap", 32'(cyc - t1), 32'd17);
        chk("t5_p2", out_p, 32'h00010000);
        @(negedge in_clk);

        // asynchronous reset mid-operation
        d0 = done_cnt;
        in_a = 16'h1234; in_b = 16'h5678; in_start = 1'b1;
        @(negedge in_clk); in_start = 1'b0;
        repeat (7) @(negedge in_clk);
        #2 in_reset = 1'b1;
        #1;
        chk("t6_busy", {31'd0, out_busy}, 32'd0);
        chk("t6_done", {31'd0, out_done}, 32'd0);
        chk("t6_p", out_p, 32'd0);
        @(negedge in_clk); in_reset = 1'b0;
        repeat (20) @(negedge in_clk);
        chk("t6_ndone", 32'(done_cnt - d0), 32'd0);
        do_op("t6b", 16'd6, 16'd7, 32'h0000002A);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            do_op("rand", ra, rb, 32'(ra) * 32'(rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
